lid_cnt_datapath: RTL and testbench
===================================

// Module: lid_cnt_datapath
// PURPOSE
//  - Consumer side of the load/inc/dec counter next-state interface.
//  - Registers the 3-bit next_state from the next-state block and executes that state's action on a WIDTH-bit count register.
//  - Drives count, status flags and the current state back to the next-state block and to downstream display/compare logic.
// PARAMETERS
//  - WIDTH  8  count/data width in bits (>=2)
// PORTS
//  - clk         in   1      single clock, rising edge
//  - reset       in   1      synchronous, active-high reset
//  - next_state  in   3      encoded next state from the next-state block
//  - d_in        in   WIDTH  load value, sampled when next_state==LOAD
//  - state       out  3      registered current state (feeds the next-state block)
//  - count       out  WIDTH  registered count value
//  - zero        out  1      combinational: count==0
//  - max         out  1      combinational: count==all ones
//  - ovf         out  1      registered 1-cycle pulse: wrap or clamp occurred
//  - err         out  1      registered 1-cycle pulse: illegal next_state code
// BEHAVIOUR
//  - Encodings: IDLE=000, LOAD=001, INC=010, INC2=011, DEC=100, DEC2=101; 110/111 are illegal.
//  - Reset (clk edge with reset=1): state=IDLE, count=0, ovf=0, err=0; reset has priority over every other input.
//  - Each edge without reset: state<=next_state and count<=f(next_state,count). The count reflects the action of the state just entered (0-cycle extra latency).
//  - Per-state action:
//    - IDLE: hold
//    - LOAD: count<=d_in
//    - INC and INC2: count+1
//    - DEC and DEC2: count-1
//  - INC/INC2 and DEC/DEC2 are alternating-phase states. Both states in a pair step by exactly 1.
//  - Arithmetic is unsigned modulo 2^WIDTH by default.
//  - ovf=1 for one cycle when INC/INC2 is entered with count=max, or when DEC/DEC2 is entered with count=0.
//  - ovf=0 for LOAD, including LOAD of d_in=0 or d_in=max.
//  - Illegal next_state (110/111): state<=IDLE, count held, err=1 for one cycle, ovf=0.
//  - Back-to-back states of any kind are legal; no stall or handshake.
//  - Reset mid-sequence discards any pending action; the first post-reset edge acts on next_state normally.
//  - zero and max derive only from the count register; no input-to-output combinational path.
// CONFIGURATION
//  - Macro LID_CNT_SATURATE_EN:
//    - Defined: INC at max holds max; DEC at 0 holds 0; ovf pulses on each clamped step.
//    - Undefined: modulo wrap (max+1->0, 0-1->max); ovf pulses on each wrap.
//    - State transitions and err are identical in both builds.
// STRUCTURE
//  - Package lid_cnt_pkg holds:
//    - the 3-bit state typedef
//    - the six state localparams
//    - a helper function is_legal_state()
//  - This package is shared with the next-state block.
//  - One sub-module, lid_step_unit (combinational):
//    - inputs: state code, count, d_in
//    - outputs: next count, ovf_d, err_d
//    - carries the SATURATE_EN branch.
//  - Top level holds only the state, count, ovf and err flops.
// TESTING
//  - T1 reset: hold reset 2 cycles, next_state=LOAD, d_in=8'h5A -> state=000, count=00, ovf=0, err=0.
//  - T2 load/step:
//    - LOAD d_in=8'hA5 -> count=A5.
//    - Then INC, INC2 -> A6, A7.
//    - Then DEC, DEC2 -> A6, A5.
//  - T3 wrap up: LOAD FF, INC:
//    - Wrap build: count=00, ovf=1 for 1 cycle, zero=1.
//    - SAT build: count=FF, ovf=1.
//  - T4 wrap down: LOAD 00, DEC:
//    - Wrap build: count=FF, max=1, ovf=1.
//    - SAT build: count=00, ovf=1.
//  - T5 illegal code: count=3C, next_state=110 -> state=000, count=3C, err=1 for exactly one cycle.
//  - T6 reset mid-run: INC stream from 10, assert reset at count=13 -> next edge count=00, state=000, no ovf/err.

Source files
------------

// File: rtl/lid_cnt_pkg.sv
// Shared encodings for the load/inc/dec counter: state codes and legality check.
// Used by both the next-state block and the datapath.
package lid_cnt_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle = 3'b000;
    localparam state_t StLoad = 3'b001;
    localparam state_t StInc  = 3'b010;
    localparam state_t StInc2 = 3'b011;
    localparam state_t StDec  = 3'b100;
    localparam state_t StDec2 = 3'b101;

    // Codes 110 and 111 are unused and treated as illegal.
    function automatic logic is_legal_state(input state_t code);
        return code <= StDec2;
    endfunction

endpackage

// File: rtl/lid_cnt_datapath_if.sv
// Bus between the counter next-state block (master) and the datapath (slave).
interface lid_cnt_datapath_if
    import lid_cnt_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    state_t             next_state;
    logic [WIDTH-1:0]   d_in;
    state_t             state;
    logic [WIDTH-1:0]   count;
    logic               zero;
    logic               max;
    logic               ovf;
    logic               err;

    modport master (
        output next_state, d_in,
        input  state, count, zero, max, ovf, err
    );

    modport slave (
        input  next_state, d_in,
        output state, count, zero, max, ovf, err
    );

endinterface

// File: rtl/lid_step_unit.sv
// Combinational per-state action on the count: next count plus ovf/err pulses.
// LID_CNT_SATURATE_EN selects clamping at the ends instead of modulo wrap.
module lid_step_unit
    import lid_cnt_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  state_t           state_i,
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] d_in_i,
    output logic [WIDTH-1:0] count_o,
    output logic             ovf_o,
    output logic             err_o
);

    logic at_max;
    logic at_zero;

    assign at_max  = (count_i == {WIDTH{1'b1}});
    assign at_zero = (count_i == '0);

    always_comb begin
        count_o = count_i;
        ovf_o   = 1'b0;
        err_o   = 1'b0;
        if (!is_legal_state(state_i)) begin
            err_o = 1'b1;
        end else begin
            case (state_i)
                StLoad: count_o = d_in_i;
                StInc, StInc2: begin
                    ovf_o = at_max;
`ifdef LID_CNT_SATURATE_EN
                    count_o = at_max ? count_i : count_i + WIDTH'(1);
`else
                    count_o = count_i + WIDTH'(1);
`endif
                end
                StDec, StDec2: begin
                    ovf_o = at_zero;
`ifdef LID_CNT_SATURATE_EN
                    count_o = at_zero ? count_i : count_i - WIDTH'(1);
`else
                    count_o = count_i - WIDTH'(1);
`endif
                end
                default: count_o = count_i;
            endcase
        end
    end

endmodule

// File: rtl/lid_cnt_datapath.sv
// Registers next_state and applies its action to the count; flags derive from the count register.
// Optional clamping build via LID_CNT_SATURATE_EN (see lid_step_unit).
module lid_cnt_datapath
    import lid_cnt_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    lid_cnt_datapath_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    lid_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .state_i (bus.next_state),
        .count_i (count_q),
        .d_in_i  (bus.d_in),
        .count_o (count_d),
        .ovf_o   (ovf_d),
        .err_o   (err_d)
    );

    // Illegal codes fall back to IDLE so the next-state block always sees a valid state.
    assign state_d = is_legal_state(bus.next_state) ? bus.next_state : StIdle;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign bus.state = state_q;
    assign bus.count = count_q;
    assign bus.zero  = (count_q == '0);
    assign bus.max   = (count_q == {WIDTH{1'b1}});
    assign bus.ovf   = ovf_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_lid_cnt_datapath.sv
// Self-checking bench for lid_cnt_datapath: directed vector table, reset-mid-run sequence,
// and random stimulus against an arithmetic reference model. Honours LID_CNT_SATURATE_EN.
module tb_lid_cnt_datapath;

    localparam int unsigned W    = 8;
    localparam int          MAXV = (1 << W) - 1;
`ifdef LID_CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        string        name;
        logic         rst;
        logic [2:0]   ns;
        logic [W-1:0] din;
        logic [2:0]   st;
        logic [W-1:0] cnt;
        logic         z;
        logic         m;
        logic         o;
        logic         e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[$];

    int   m_st;
    int   m_cnt;
    bit   m_o;
    bit   m_e;

    lid_cnt_datapath_if #(.WIDTH(W)) bus ();

    lid_cnt_datapath #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void add(string name, logic rst, logic [2:0] ns, logic [W-1:0] din,
                                logic [2:0] st, logic [W-1:0] cnt, logic o, logic e);
        vec_t v;
        v.name = name; v.rst = rst; v.ns = ns; v.din = din;
        v.st = st; v.cnt = cnt; v.o = o; v.e = e;
        v.z = (cnt == 0);
        v.m = (cnt == W'(MAXV));
        vecs.push_back(v);
    endfunction

    task automatic apply(input logic rst, input logic [2:0] ns, input logic [W-1:0] din);
        @(negedge clk);
        reset          = rst;
        bus.next_state = ns;
        bus.d_in       = din;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic [W-1:0] cnt,
                         input logic z, input logic m, input logic o, input logic e);
        logic [W+6:0] act, exp_v;
        act   = {bus.state, bus.count, bus.zero, bus.max, bus.ovf, bus.err};
        exp_v = {st, cnt, z, m, o, e};
        n_checks++;
        if (act === exp_v) n_pass++;
        else
            $display("FAIL %s: got state=%b count=%h zero=%b max=%b ovf=%b err=%b, required state=%b count=%h zero=%b max=%b ovf=%b err=%b",
                     name, bus.state, bus.count, bus.zero, bus.max, bus.ovf, bus.err,
                     st, cnt, z, m, o, e);
    endtask

    // Reference model: plain integer arithmetic on the state rules.
    task automatic model(input logic rst, input int ns, input int din);
        m_o = 1'b0;
        m_e = 1'b0;
        if (rst) begin
            m_st  = 0;
            m_cnt = 0;
        end else if (ns > 5) begin
            m_st = 0;
            m_e  = 1'b1;
        end else begin
            m_st = ns;
            if (ns == 1) begin
                m_cnt = din;
            end else if (ns == 2 || ns == 3) begin
                if (m_cnt == MAXV) begin
                    m_o   = 1'b1;
                    m_cnt = SAT ? MAXV : 0;
                end else m_cnt = m_cnt + 1;
            end else if (ns == 4 || ns == 5) begin
                if (m_cnt == 0) begin
                    m_o   = 1'b1;
                    m_cnt = SAT ? 0 : MAXV;
                end else m_cnt = m_cnt - 1;
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.next_state = 3'b000;
        bus.d_in       = '0;

        add("t1_reset_a", 1, 3'b001, 8'h5A, 3'b000, 8'h00, 0, 0);
        add("t1_reset_b", 1, 3'b001, 8'h5A, 3'b000, 8'h00, 0, 0);
        add("t2_load",    0, 3'b001, 8'hA5, 3'b001, 8'hA5, 0, 0);
        add("t2_inc",     0, 3'b010, 8'h00, 3'b010, 8'hA6, 0, 0);
        add("t2_inc2",    0, 3'b011, 8'h00, 3'b011, 8'hA7, 0, 0);
        add("t2_dec",     0, 3'b100, 8'h00, 3'b100, 8'hA6, 0, 0);
        add("t2_dec2",    0, 3'b101, 8'h00, 3'b101, 8'hA5, 0, 0);
        add("t2_idle",    0, 3'b000, 8'h33, 3'b000, 8'hA5, 0, 0);
        add("t3_load_ff", 0, 3'b001, 8'hFF, 3'b001, 8'hFF, 0, 0);
        add("t3_inc_top", 0, 3'b010, 8'h00, 3'b010, SAT ? 8'hFF : 8'h00, 1, 0);
        add("t3_ovf_end", 0, 3'b000, 8'h00, 3'b000, SAT ? 8'hFF : 8'h00, 0, 0);
        add("t4_load_00", 0, 3'b001, 8'h00, 3'b001, 8'h00, 0, 0);
        add("t4_dec_bot", 0, 3'b100, 8'h00, 3'b100, SAT ? 8'h00 : 8'hFF, 1, 0);
        add("t4_ovf_end", 0, 3'b000, 8'h00, 3'b000, SAT ? 8'h00 : 8'hFF, 0, 0);
        add("t5_load_3c", 0, 3'b001, 8'h3C, 3'b001, 8'h3C, 0, 0);
        add("t5_ill_110", 0, 3'b110, 8'h77, 3'b000, 8'h3C, 0, 1);
        add("t5_err_end", 0, 3'b000, 8'h77, 3'b000, 8'h3C, 0, 0);
        add("t5_ill_111", 0, 3'b111, 8'h00, 3'b000, 8'h3C, 0, 1);
        add("t5_ill_b2b", 0, 3'b110, 8'h00, 3'b000, 8'h3C, 0, 1);
        add("t5_inc_aft", 0, 3'b011, 8'h00, 3'b011, 8'h3D, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].ns, vecs[i].din);
            check(vecs[i].name, vecs[i].st, vecs[i].cnt, vecs[i].z, vecs[i].m, vecs[i].o,
                  vecs[i].e);
        end

        // Reset in the middle of an INC stream discards the pending step.
        apply(0, 3'b001, 8'h10);
        check("t6_load", 3'b001, 8'h10, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            apply(0, (k % 2 == 1) ? 3'b010 : 3'b011, 8'h00);
            check("t6_inc", (k % 2 == 1) ? 3'b010 : 3'b011, W'(8'h10 + k), 0, 0, 0, 0);
        end
        apply(1, 3'b010, 8'h00);
        check("t6_reset", 3'b000, 8'h00, 1, 0, 0, 0);
        apply(0, 3'b010, 8'h00);
        check("t6_post", 3'b010, 8'h01, 0, 0, 0, 0);

        model(1, 0, 0);
        apply(1, 3'b000, 8'h00);
        check("rnd_reset", 3'(m_st), W'(m_cnt), m_cnt == 0, m_cnt == MAXV, m_o, m_e);
        for (int k = 0; k < 400; k++) begin
            logic         r;
            logic [2:0]   ns;
            logic [W-1:0] din;
            r   = ($urandom_range(0, 39) == 0);
            ns  = 3'($urandom_range(0, 7));
            // Bias loads toward the ends so wrap/clamp paths get exercised.
            case ($urandom_range(0, 3))
                0:       din = '0;
                1:       din = '1;
                default: din = W'($urandom);
            endcase
            model(r, int'(ns), int'(din));
            apply(r, ns, din);
            check("rnd", 3'(m_st), W'(m_cnt), m_cnt == 0, m_cnt == MAXV, m_o, m_e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
